// File: rtl/frame_mem_arbiter_pkg.sv
// Shared types and default sizes for the frame memory arbiter.
package frame_mem_arbiter_pkg;

  // Bit 0 marks a write on the memory port and bit 1 marks a read.
  // The grant outputs come straight from these state bits.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WR   = 2'b01,
    RD   = 2'b10
  } arb_state_t;

  localparam int DEF_ADDR_W        = 19;
  localparam int DEF_DATA_W        = 8;
  localparam int DEF_RD_LAT        = 2;
  localparam int DEF_MAX_WR_STREAK = 4;

  function automatic int streak_width(input int max_streak);
    return (max_streak < 1) ? 1 : $clog2(max_streak + 1);
  endfunction

endpackage

// File: rtl/frame_mem_arbiter_if.sv
// Bundle for the camera write port, the reader port and the frame memory port.
interface frame_mem_arbiter_if
  import frame_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_gnt;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_gnt;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              frame_done;
  logic [ADDR_W:0]   mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;

  modport slave (
    input  wr_req, wr_addr, wr_data, rd_req, rd_addr, frame_done, mem_dout,
    output wr_gnt, rd_gnt, rd_valid, rd_data, mem_addr, mem_we, mem_din
  );

  modport master (
    output wr_req, wr_addr, wr_data, rd_req, rd_addr, frame_done, mem_dout,
    input  wr_gnt, rd_gnt, rd_valid, rd_data, mem_addr, mem_we, mem_din
  );

endinterface

// File: rtl/frame_mem_arbiter_rd_pipe.sv
// Read return tracking: a valid shift register matched to the memory latency,
// with returned data captured from mem_dout on the cycle the tag leaves the pipe.
module frame_rd_pipe
  import frame_mem_arbiter_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int RD_LAT = DEF_RD_LAT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data
);
  logic [RD_LAT-1:0] valid_reg;
  logic [RD_LAT:0]   tap;
  logic [DATA_W-1:0] rd_data_reg;

  // tap[k] is high k cycles after the read appeared on the memory port.
  assign tap = {valid_reg, issue};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_reg   <= '0;
      rd_data_reg <= '0;
    end else begin
      valid_reg <= tap[RD_LAT-1:0];
      if (tap[RD_LAT-1]) begin
        rd_data_reg <= mem_dout;
      end
    end
  end

  assign rd_valid = tap[RD_LAT];
  assign rd_data  = rd_data_reg;

endmodule

// File: rtl/frame_mem_arbiter.sv
// Write/read arbiter for a single-port pixel frame memory with bounded write streaks.
// Double buffering (bank swap on frame_done) is built only when FRAME_SWAP_EN is defined.
module frame_mem_arbiter
  import frame_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W        = DEF_ADDR_W,
  parameter int DATA_W        = DEF_DATA_W,
  parameter int RD_LAT        = DEF_RD_LAT,
  parameter int MAX_WR_STREAK = DEF_MAX_WR_STREAK
) (
  input  logic               clk,
  input  logic               reset,
  frame_mem_arbiter_if.slave bus
);
  localparam int                  STREAK_W   = streak_width(MAX_WR_STREAK);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_WR_STREAK);

  arb_state_t          state_reg;
  arb_state_t          state_next;
  logic [1:0]          state_bits;
  logic [STREAK_W-1:0] streak_reg;
  logic [STREAK_W-1:0] streak_next;
  logic                streak_full;
  logic [ADDR_W:0]     mem_addr_reg;
  logic [DATA_W-1:0]   mem_din_reg;
  logic                wr_bank;
  logic                rd_bank;
  logic                rd_valid_w;
  logic [DATA_W-1:0]   rd_data_w;

  assign streak_full = (streak_reg == STREAK_MAX);

  // Writes win unless they have already taken MAX_WR_STREAK slots in a row from a waiting read.
  always_comb begin
    state_next = IDLE;
    if (bus.wr_req && !(bus.rd_req && streak_full)) begin
      state_next = WR;
    end else if (bus.rd_req) begin
      state_next = RD;
    end
  end

  always_comb begin
    streak_next = '0;
    if (state_next == WR && bus.rd_req) begin
      streak_next = streak_full ? streak_reg : streak_reg + STREAK_W'(1);
    end
  end

`ifdef FRAME_SWAP_EN
  logic bank_reg;

  // The edge that samples frame_done still issues with the old bank.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bank_reg <= 1'b0;
    end else if (bus.frame_done) begin
      bank_reg <= ~bank_reg;
    end
  end

  assign wr_bank = bank_reg;
  assign rd_bank = ~bank_reg;
`else
  assign wr_bank = 1'b0;
  assign rd_bank = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      streak_reg   <= '0;
      mem_addr_reg <= '0;
      mem_din_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      streak_reg <= streak_next;
      case (state_next)
        WR: begin
          mem_addr_reg <= {wr_bank, bus.wr_addr};
          mem_din_reg  <= bus.wr_data;
        end
        RD: begin
          mem_addr_reg <= {rd_bank, bus.rd_addr};
        end
        default: begin
        end
      endcase
    end
  end

  assign state_bits   = state_reg;
  assign bus.wr_gnt   = state_bits[0];
  assign bus.mem_we   = state_bits[0];
  assign bus.rd_gnt   = state_bits[1];
  assign bus.mem_addr = mem_addr_reg;
  assign bus.mem_din  = mem_din_reg;

  frame_rd_pipe #(
    .DATA_W(DATA_W),
    .RD_LAT(RD_LAT)
  ) u_rd_pipe (
    .clk     (clk),
    .reset   (reset),
    .issue   (state_bits[1]),
    .mem_dout(bus.mem_dout),
    .rd_valid(rd_valid_w),
    .rd_data (rd_data_w)
  );

  assign bus.rd_valid = rd_valid_w;
  assign bus.rd_data  = rd_data_w;

endmodule

// File: tb/tb_frame_mem_arbiter.sv
// Scoreboard bench for frame_mem_arbiter: directed cases then randomized traffic
// against a request-level reference model; honours FRAME_SWAP_EN when defined.
module tb_frame_mem_arbiter;
  import frame_mem_arbiter_pkg::*;

  localparam int AW   = 19;
  localparam int DW   = 8;
  localparam int LAT  = 2;
  localparam int MAXS = 4;
`ifdef FRAME_SWAP_EN
  localparam bit SWAP = 1'b1;
`else
  localparam bit SWAP = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  frame_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  frame_mem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT), .MAX_WR_STREAK(MAXS)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Frame memory behind the arbiter: synchronous, data LAT edges after issue.
  logic [DW-1:0] env_mem [0:(1<<(AW+1))-1];
  logic [DW-1:0] rd_q;
  always @(posedge clk) begin
    if (bus.mem_we) env_mem[bus.mem_addr] <= bus.mem_din;
    rd_q <= env_mem[bus.mem_addr];
  end
  assign bus.mem_dout = rd_q;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    longint        cyc;
    bit            is_wr;
    logic [AW:0]   addr;
    logic [DW-1:0] din;
  } gnt_exp_t;

  typedef struct {
    longint        cyc;
    bit            known;
    logic [DW-1:0] data;
  } rd_exp_t;

  gnt_exp_t      gnt_q[$];
  rd_exp_t       rd_exp[$];
  int            gnt_log[$];
  logic [AW:0]   addr_log[$];
  logic [DW-1:0] model_mem [int];
  int            wr_run = 0;
  bit            m_bank = 1'b0;
  int            last_dec = 0;
  int            tests = 0;
  int            fails = 0;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one cycle of requests and predict the access the arbiter issues next cycle.
  task automatic drive_cycle(input bit w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                             input bit r, input logic [AW-1:0] ra, input bit fd);
    gnt_exp_t    e;
    rd_exp_t     x;
    logic [AW:0] a;
    bus.wr_req     = w;
    bus.wr_addr    = wa;
    bus.wr_data    = wd;
    bus.rd_req     = r;
    bus.rd_addr    = ra;
    bus.frame_done = fd;
    if (w && !(r && wr_run >= MAXS)) begin
      a = {SWAP & m_bank, wa};
      e = '{cyc: cyc + 1, is_wr: 1'b1, addr: a, din: wd};
      gnt_q.push_back(e);
      model_mem[int'(a)] = wd;
      wr_run   = r ? wr_run + 1 : 0;
      last_dec = 1;
    end else if (r) begin
      a = {SWAP & ~m_bank, ra};
      e = '{cyc: cyc + 1, is_wr: 1'b0, addr: a, din: '0};
      gnt_q.push_back(e);
      x.cyc   = cyc + 1 + LAT;
      x.known = model_mem.exists(int'(a));
      x.data  = x.known ? model_mem[int'(a)] : '0;
      rd_exp.push_back(x);
      wr_run   = 0;
      last_dec = 2;
    end else begin
      wr_run   = 0;
      last_dec = 0;
    end
    if (fd) m_bank = ~m_bank;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, '0, '0, 1'b0, '0, 1'b0);
  endtask

  // Monitor: pops an expectation whenever the DUT presents a grant or returned data.
  initial begin : monitor
    gnt_exp_t e;
    rd_exp_t  x;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        if (bus.wr_gnt || bus.rd_gnt) begin
          check("gnt_exclusive", bus.wr_gnt && bus.rd_gnt, 0);
          gnt_log.push_back(bus.wr_gnt ? 1 : 2);
          addr_log.push_back(bus.mem_addr);
          check("gnt_expected", gnt_q.size() > 0, 1);
          if (gnt_q.size() > 0) begin
            e = gnt_q.pop_front();
            check("gnt_cycle", cyc, e.cyc);
            check("gnt_is_write", bus.wr_gnt, e.is_wr);
            check("mem_we", bus.mem_we, e.is_wr);
            check("mem_addr", bus.mem_addr, e.addr);
            if (e.is_wr) check("mem_din", bus.mem_din, e.din);
          end
          $display("[TB] cyc %0d %s addr=0x%05h din=0x%02h", cyc,
                   bus.wr_gnt ? "WR" : "RD", bus.mem_addr, bus.mem_din);
        end else begin
          check("mem_we_idle", bus.mem_we, 0);
        end
        if (bus.rd_valid) begin
          check("rd_valid_expected", rd_exp.size() > 0, 1);
          if (rd_exp.size() > 0) begin
            x = rd_exp.pop_front();
            check("rd_valid_cycle", cyc, x.cyc);
            if (x.known) check("rd_data", bus.rd_data, x.data);
          end
          $display("[TB] cyc %0d RDATA data=0x%02h", cyc, bus.rd_data);
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, got running, want finished");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int          pat [10] = '{1, 1, 1, 1, 2, 1, 1, 1, 1, 2};
    logic [AW:0] swap_exp;
    bit          wp, rp, fd;
    logic [AW-1:0] wa, ra;
    logic [DW-1:0] wd;

    bus.wr_req = 0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.rd_req = 0; bus.rd_addr = '0; bus.frame_done = 0;

    repeat (3) @(negedge clk);
    check("rst_wr_gnt", bus.wr_gnt, 0);
    check("rst_rd_gnt", bus.rd_gnt, 0);
    check("rst_rd_valid", bus.rd_valid, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_din", bus.mem_din, 0);
    check("rst_rd_data", bus.rd_data, 0);
    reset = 1'b1;

    // Single write, then a single read of a location holding 0x5C.
    drive_cycle(1, 19'h00010, 8'hAB, 0, '0, 0);
    idle(1);
    drive_cycle(1, 19'h12345, 8'h5C, 0, '0, 0);
    idle(1);
    drive_cycle(0, '0, '0, 1, 19'h12345, 0);
    idle(4);

    // Both requesters held for ten cycles.
    gnt_log.delete();
    for (int i = 0; i < 10; i++) drive_cycle(1, 19'h00020, 8'h11, 1, 19'h12345, 0);
    idle(4);
    check("streak_len", gnt_log.size(), 10);
    for (int i = 0; i < 10 && i < gnt_log.size(); i++) check($sformatf("streak_seq[%0d]", i), gnt_log[i], pat[i]);

    // Frame swap: write, frame_done, same write address, then a read.
    addr_log.delete();
    drive_cycle(1, 19'h00100, 8'h21, 0, '0, 0);
    drive_cycle(0, '0, '0, 0, '0, 1);
    drive_cycle(1, 19'h00100, 8'h22, 0, '0, 0);
    drive_cycle(0, '0, '0, 1, 19'h00200, 0);
    idle(4);
    swap_exp = SWAP ? 20'h80100 : 20'h00100;
    check("swap_log_len", addr_log.size(), 3);
    if (addr_log.size() == 3) begin
      check("swap_wr0_addr", addr_log[0], 20'h00100);
      check("swap_wr1_addr", addr_log[1], swap_exp);
      check("swap_rd_addr", addr_log[2], 20'h00200);
    end

    // Reset one cycle after a read grant must discard its return.
    drive_cycle(0, '0, '0, 1, 19'h12345, 0);
    drive_cycle(0, '0, '0, 0, '0, 0);
    rd_exp.delete();
    gnt_q.delete();
    reset = 1'b0;
    #1;
    check("mid_rst_wr_gnt", bus.wr_gnt, 0);
    check("mid_rst_rd_gnt", bus.rd_gnt, 0);
    check("mid_rst_rd_valid", bus.rd_valid, 0);
    check("mid_rst_mem_we", bus.mem_we, 0);
    check("mid_rst_mem_addr", bus.mem_addr, 0);
    check("mid_rst_mem_din", bus.mem_din, 0);
    check("mid_rst_rd_data", bus.rd_data, 0);
    wr_run = 0;
    m_bank = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive_cycle(0, '0, '0, 0, '0, 0);
      check("post_rst_rd_valid", bus.rd_valid, 0);
    end

    // Randomized traffic: requests held until granted, occasional frame_done.
    wp = 0; rp = 0; wa = '0; ra = '0; wd = '0;
    for (int i = 0; i < 600; i++) begin
      if (!wp && $urandom_range(0, 99) < 60) begin
        wp = 1;
        wa = AW'($urandom_range(0, 63));
        wd = DW'($urandom);
      end
      if (!rp && $urandom_range(0, 99) < 50) begin
        rp = 1;
        ra = AW'($urandom_range(0, 63));
      end
      fd = ($urandom_range(0, 39) == 0);
      drive_cycle(wp, wa, wd, rp, ra, fd);
      if (last_dec == 1) wp = 0;
      if (last_dec == 2) rp = 0;
    end
    idle(6);
    check("gnt_queue_drained", gnt_q.size(), 0);
    check("rd_queue_drained", rd_exp.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
